fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register. Owns the PC and fetches from an instruction memory with

---
 rtl/cpu_pkg.sv | 10 +
 rtl/if_id_reg.sv | 18 +
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch stage and IF/ID register
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_HELD, S_DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output if_id_t      q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        else if (load) q <= '{pc: pc, instr: instr, valid: 1'b1};
        else if (bubble) q <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, variable-latency imem fetch FSM and IF/ID register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_id_flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);
    fetch_state_t state, state_n;
    logic [31:0] pc, pc_n, req_addr, req_addr_n, held_pc, held_pc_n, held_instr, held_instr_n;
    logic [31:0] ld_pc, ld_instr;
    logic load, bubble;
    if_id_t q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_addr   <= 32'd0;
            held_pc    <= 32'd0;
            held_instr <= 32'd0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            held_pc    <= held_pc_n;
            held_instr <= held_instr_n;
        end
    end
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_addr_n   = req_addr;
        held_pc_n    = held_pc;
        held_instr_n = held_instr;
        load         = 1'b0;
        bubble       = 1'b0;
        ld_pc        = pc;
        ld_instr     = imem_rdata;
        if (if_id_flush) begin
            bubble = 1'b1;
            pc_n   = branch_target & ~32'h3;
            // an unanswered request must be drained before the target can be fetched
            if (state == S_REQ && !imem_rvalid) begin
                state_n    = S_DROP;
                req_addr_n = pc;
            end else if (state != S_DROP || imem_rvalid) begin
                state_n = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_rvalid && stall) begin
                        held_pc_n    = pc;
                        held_instr_n = imem_rdata;
                        state_n      = S_HELD;
                    end else if (!stall) begin
                        load   = imem_rvalid;
                        bubble = !imem_rvalid;
                        pc_n   = imem_rvalid ? pc + 32'd4 : pc;
                    end
                end
                S_HELD: begin
                    if (!stall) begin
                        load     = 1'b1;
                        ld_pc    = held_pc;
                        ld_instr = held_instr;
                        pc_n     = pc + 32'd4;
                        state_n  = S_REQ;
                    end
                end
                S_DROP: begin
                    bubble  = !stall;
                    state_n = imem_rvalid ? S_REQ : S_DROP;
                end
                default: state_n = S_REQ;
            endcase
        end
    end
    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .bubble(bubble),
        .pc    (ld_pc),
        .instr (ld_instr),
        .q     (q)
    );
    assign imem_req    = state != S_HELD;
    assign imem_addr   = state == S_DROP ? req_addr : pc;
    assign if_id_pc    = q.pc;
    assign if_id_instr = q.instr;
    assign if_id_valid = q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with a wait-state imem model
module tb_fetch_stage;
    import cpu_pkg::*;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          gap;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, if_id_flush = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic imem_req, imem_rvalid, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
    int mem_wait = 0;
    logic [7:0] wait_cnt;
    exp_t sb[$];
    int errs = 0, checks = 0, gap = 0;
    logic rst_q = 1'b1, stall_q = 1'b0, flush_q = 1'b0;
    logic prev_pend = 1'b0, prev_valid;
    logic [31:0] prev_addr, prev_pc, prev_instr;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .if_id_flush  (if_id_flush),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    always #5 clk = ~clk;

    // memory answers after mem_wait idle cycles; 0 means same-cycle response
    assign imem_rvalid = imem_req && (int'(wait_cnt) >= mem_wait);
    assign imem_rdata  = imem_addr ^ 32'hA5A5_0000;
    always @(posedge clk) begin
        wait_cnt <= (rst || !imem_req || imem_rvalid) ? 8'd0 : wait_cnt + 8'd1;
        rst_q    <= rst;
        stall_q  <= stall;
        flush_q  <= if_id_flush;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("rst_valid", 32'(if_id_valid), 32'd0);
            check("rst_instr", if_id_instr, NOP_INSTR);
            check("rst_pc", if_id_pc, 32'd0);
            check("rst_addr", imem_addr, 32'd0);
            check("rst_req", 32'(imem_req), 32'd1);
            gap = 0;
        end else if (stall_q && !flush_q) begin
            check("frz_valid", 32'(if_id_valid), 32'(prev_valid));
            check("frz_pc", if_id_pc, prev_pc);
            check("frz_instr", if_id_instr, prev_instr);
        end else if (if_id_valid) begin
            if (sb.size() == 0) check("sb_underflow", if_id_pc, 32'hxxxx_xxxx);
            else begin
                e = sb.pop_front();
                check("sb_pc", if_id_pc, e.pc);
                check("sb_instr", if_id_instr, e.instr);
                if (e.gap >= 0) check("sb_gap", 32'(gap), 32'(e.gap));
            end
            gap = 0;
        end else begin
            check("bubble_nop", if_id_instr, NOP_INSTR);
            gap++;
        end
        if (flush_q && !rst_q) check("flush_bubble", 32'(if_id_valid), 32'd0);
        if (prev_pend && !rst_q) check("addr_stable", imem_addr, prev_addr);
        prev_pend  = imem_req && !imem_rvalid;
        prev_addr  = imem_addr;
        prev_valid = if_id_valid;
        prev_pc    = if_id_pc;
        prev_instr = if_id_instr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input int g);
        exp_t e;
        e = '{pc: a, instr: a ^ 32'hA5A5_0000, gap: g};
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        tick;
        rst = 1'b0;
    endtask

    initial begin
        // zero-wait streaming
        mem_wait = 0;
        do_reset;
        for (int i = 0; i < 8; i++) push(32'(i * 4), 0);
        repeat (8) tick;
        // two bubbles per instruction
        mem_wait = 2;
        do_reset;
        for (int i = 0; i < 3; i++) push(32'(i * 4), 2);
        repeat (9) tick;
        // stall while a response arrives at pc 0x10
        mem_wait = 0;
        do_reset;
        for (int i = 0; i < 7; i++) push(32'(i * 4), 0);
        repeat (4) tick;
        stall = 1'b1;
        repeat (2) tick;
        stall = 1'b0;
        repeat (3) tick;
        // flush while a slow request to 0x08 is pending
        mem_wait = 2;
        do_reset;
        push(32'h0, 2);
        push(32'h4, 2);
        push(32'h40, 5);
        push(32'h44, 2);
        repeat (6) tick;
        if_id_flush = 1'b1;
        branch_target = 32'h42;
        tick;
        if_id_flush = 1'b0;
        repeat (8) tick;
        // wrap at the top of memory, then flush+stall in the held state
        mem_wait = 0;
        do_reset;
        push(32'hFFFF_FFFC, 1);
        push(32'h80, 1);
        push(32'h84, 0);
        if_id_flush = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick;
        if_id_flush = 1'b0;
        tick;
        check("wrap_addr", imem_addr, 32'h0);
        stall = 1'b1;
        tick;
        if_id_flush = 1'b1;
        branch_target = 32'h80;
        tick;
        check("redirect_addr", imem_addr, 32'h80);
        stall = 1'b0;
        if_id_flush = 1'b0;
        repeat (2) tick;
        // reset in the middle of a drain
        mem_wait = 3;
        do_reset;
        if_id_flush = 1'b1;
        branch_target = 32'h100;
        tick;
        if_id_flush = 1'b0;
        check("drop_addr", imem_addr, 32'h0);
        do_reset;
        push(32'h0, 3);
        push(32'h4, 3);
        repeat (8) tick;
        do_reset;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
